addsub_pipe: RTL and testbench

ADDSUB_PIPE -- requirements
Module: addsub_pipe

---
 rtl/addsub_pipe.sv | 121 ++++++++++++
 tb/tb_addsub_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
// Single-stage add/subtract/accumulate unit with valid/ready handshake on both sides.
// Optional signed saturation; flags are registered together with the result.
module addsub_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ACC  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_out_valid;
    logic             r_carry;
    logic             r_overflow;
    logic             r_zero;
    logic             r_negative;

    logic             w_accept;
    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_opb;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf_raw;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Subtract is a + ~b + 1, so both overflow and saturation look at the effective B.
    always_comb begin
        w_opa = a;
        w_opb = b;
        w_cin = 1'b0;
        case (op)
            OP_SUB: begin
                w_opb = ~b;
                w_cin = 1'b1;
            end
            OP_ACC: begin
                w_opa = r_acc;
                w_opb = a;
            end
            default: begin
                w_opa = a;
                w_opb = b;
            end
        endcase
    end

    assign w_sum     = {1'b0, w_opa} + {1'b0, w_opb} + {{WIDTH{1'b0}}, w_cin};
    assign w_ovf_raw = (w_opa[WIDTH-1] == w_opb[WIDTH-1]) && (w_sum[WIDTH-1] != w_opa[WIDTH-1]);

    always_comb begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = w_ovf_raw;
        if (op == OP_LOAD) begin
            w_res   = a;
            w_carry = 1'b0;
            w_ovf   = 1'b0;
        end else if (sat && w_ovf_raw) begin
            w_res = w_opa[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b1;
            r_negative  <= 1'b0;
            r_acc       <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_carry     <= w_carry;
            r_overflow  <= w_ovf;
            r_zero      <= (w_res == '0);
            r_negative  <= w_res[WIDTH-1];
            // Accumulate and load both leave the final result in acc.
            if (op == OP_ACC || op == OP_LOAD) begin
                r_acc <= w_res;
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign carry     = r_carry;
    assign overflow  = r_overflow;
    assign zero      = r_zero;
    assign negative  = r_negative;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe (WIDTH=8): directed vector table, stall/reset sequences,
// and randomized handshake traffic checked against an integer-arithmetic model.
module tb_addsub_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic       sat;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry;
    logic       overflow;
    logic       zero;
    logic       negative;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    addsub_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .sat(sat),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .overflow(overflow),
        .zero(zero), .negative(negative)
    );

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       sat;
        logic [7:0] res;
        logic       c;
        logic       v;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_out(input string name, input logic [7:0] er, input logic ec, input logic ev);
        chk({name, ".valid"}, 64'(out_valid), 64'd1);
        chk({name, ".result"}, 64'(result), 64'(er));
        chk({name, ".carry"}, 64'(carry), 64'(ec));
        chk({name, ".overflow"}, 64'(overflow), 64'(ev));
        chk({name, ".zero"}, 64'(zero), 64'(er == 8'h00));
        chk({name, ".negative"}, 64'(negative), 64'(er[7]));
    endtask

    task automatic beat(input logic [1:0] o, input logic [7:0] aa, input logic [7:0] bb,
                        input logic s, input logic ordy);
        @(negedge clk);
        in_valid  = 1'b1;
        op        = o;
        a         = aa;
        b         = bb;
        sat       = s;
        out_ready = ordy;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Reference: plain signed/unsigned integer arithmetic on the operation's meaning.
    function automatic void ref_op(input logic [1:0] o, input logic [7:0] aa, input logic [7:0] bb,
                                   input logic s, input logic [7:0] acc_in,
                                   output logic [7:0] res, output logic c, output logic v,
                                   output logic [7:0] acc_out);
        int ux, uy, us, sx, sy, ss;
        acc_out = acc_in;
        if (o == 2'b11) begin
            res = aa; c = 1'b0; v = 1'b0; acc_out = aa;
            return;
        end
        ux = (o == 2'b10) ? int'(acc_in) : int'(aa);
        uy = (o == 2'b10) ? int'(aa) : int'(bb);
        sx = (ux > 127) ? ux - 256 : ux;
        sy = (uy > 127) ? uy - 256 : uy;
        if (o == 2'b01) begin
            us = ux - uy;
            ss = sx - sy;
            c  = (ux >= uy);
        end else begin
            us = ux + uy;
            ss = sx + sy;
            c  = (us > 255);
        end
        v = (ss > 127) || (ss < -128);
        if (s && ss > 127)       res = 8'h7F;
        else if (s && ss < -128) res = 8'h80;
        else                     res = 8'(us & 255);
        if (o == 2'b10) acc_out = res;
    endfunction

    initial begin
        logic       m_valid;
        logic [7:0] m_res, m_acc, n_acc;
        logic       m_c, m_v;
        logic       exp_rdy;

        vecs[0]  = '{2'b00, 8'hCC, 8'h33, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[1]  = '{2'b01, 8'hCC, 8'hB3, 1'b0, 8'h19, 1'b1, 1'b0};
        vecs[2]  = '{2'b01, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0};
        vecs[3]  = '{2'b00, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4]  = '{2'b00, 8'h7F, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1};
        vecs[5]  = '{2'b00, 8'h80, 8'hFF, 1'b1, 8'h80, 1'b1, 1'b1};
        vecs[6]  = '{2'b11, 8'h05, 8'hAA, 1'b1, 8'h05, 1'b0, 1'b0};
        vecs[7]  = '{2'b10, 8'h03, 8'hFF, 1'b0, 8'h08, 1'b0, 1'b0};
        vecs[8]  = '{2'b00, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[9]  = '{2'b10, 8'h03, 8'h00, 1'b0, 8'h0B, 1'b0, 1'b0};
        vecs[10] = '{2'b10, 8'h03, 8'h00, 1'b0, 8'h0E, 1'b0, 1'b0};
        vecs[11] = '{2'b01, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[12] = '{2'b10, 8'hF2, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[13] = '{2'b11, 8'h7F, 8'h00, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[14] = '{2'b10, 8'h01, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1};
        vecs[15] = '{2'b10, 8'h01, 8'h00, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[16] = '{2'b01, 8'h00, 8'h80, 1'b1, 8'h7F, 1'b0, 1'b1};
        vecs[17] = '{2'b01, 8'h80, 8'h01, 1'b1, 8'h80, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        a = 8'h11; b = 8'h22; op = 2'b00; sat = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.result", 64'(result), 64'd0);
        chk("rst.flags", 64'({carry, overflow, zero, negative}), 64'b0010);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

        // Directed table, one beat per vector with downstream always ready.
        for (int i = 0; i < 18; i++) begin
            beat(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sat, 1'b1);
            chk_out($sformatf("vec%0d", i), vecs[i].res, vecs[i].c, vecs[i].v);
        end

        // Drain without accept: valid drops, result and flags hold.
        @(posedge clk); #1;
        chk("drain.valid", 64'(out_valid), 64'd0);
        chk("drain.result", 64'(result), 64'h80);
        chk("drain.flags", 64'({carry, overflow, zero, negative}), 64'b1101);

        // Stall: one beat pending, later offers ignored, then back-to-back stream.
        beat(2'b00, 8'h10, 8'h01, 1'b0, 1'b0);
        chk_out("stall.first", 8'h11, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1; op = 2'b01; a = 8'(8'h40 + k); b = 8'h03; sat = 1'b1;
            #1;
            chk("stall.in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
            chk_out("stall.hold", 8'h11, 1'b0, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            beat(2'b00, 8'(8'h20 + k), 8'h01, 1'b0, 1'b1);
            chk_out($sformatf("stream%0d", k), 8'(8'h21 + k), 1'b0, 1'b0);
        end
        @(posedge clk); #1;
        chk("stream.end_valid", 64'(out_valid), 64'd0);

        // Reset while stalled with a loaded accumulator.
        beat(2'b11, 8'h55, 8'h00, 1'b0, 1'b0);
        chk_out("prerst", 8'h55, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; op = 2'b00; a = 8'h01; b = 8'h01;
        @(posedge clk); #1;
        chk("midrst.valid", 64'(out_valid), 64'd0);
        chk("midrst.zero", 64'(zero), 64'd1);
        chk("midrst.result", 64'(result), 64'd0);
        chk("midrst.in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("midrst.discard", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        beat(2'b10, 8'h02, 8'h00, 1'b0, 1'b1);
        chk_out("postrst.acc", 8'h02, 1'b0, 1'b0);

        // Randomized traffic: model holds acc and one pending output.
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_valid = 1'b0; m_acc = 8'h00; m_res = 8'h00; m_c = 1'b0; m_v = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            op        = 2'($urandom_range(0, 3));
            sat       = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       a = 8'h7F;
                1:       a = 8'h80;
                default: a = 8'($urandom);
            endcase
            b = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom);
            #1;
            exp_rdy = !m_valid || out_ready;
            chk("rnd.in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("rnd.out_valid", 64'(out_valid), 64'(m_valid));
            if (m_valid) begin
                chk("rnd.out", 64'({result, carry, overflow, zero, negative}),
                    64'({m_res, m_c, m_v, m_res == 8'h00, m_res[7]}));
            end
            if (in_valid && exp_rdy) begin
                ref_op(op, a, b, sat, m_acc, m_res, m_c, m_v, n_acc);
                m_acc   = n_acc;
                m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("rnd.last_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) chk("rnd.last_result", 64'(result), 64'(m_res));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
